// File: rtl/fpga_config_pkg.sv
// Shared constants and FSM encoding for the configuration bitstream loader.
//   WORD_W          : configuration frame width in bits (multiple of 8)
//   NUM_FRAMES      : number of frames in a full bitstream
//   BYTES_PER_FRAME : bytes needed to assemble one frame
//   SETTLE_CYCLES   : idle cycles between the last commit and ff_en
package fpga_config_pkg;

    localparam int WORD_W          = 224;
    localparam int NUM_FRAMES      = 43;
    localparam int BYTES_PER_FRAME = WORD_W / 8;
    localparam int SETTLE_CYCLES   = 10;

    typedef enum logic [2:0] {
        LOAD,
        COMMIT,
        SETTLE,
        ENABLE,
        DONE
    } cfg_state_t;

endpackage

// File: rtl/fpga_config_loader.sv
// Bitstream receiver: assembles bytes (MSB byte first) into WORD_W-bit frames
// and strobes each frame into the fabric, then enables fabric flops.
// Ports:
//   clock      : sole clock, rising edge
//   rst        : synchronous active-high reset
//   bs_data    : bitstream byte
//   bs_valid   : bs_data valid
//   bs_ready   : byte can be accepted (LOAD state only)
//   configs_in : assembled frame data
//   configs_en : one-hot single-cycle frame write strobe
//   ff_en      : fabric flip-flop enable
//   rdy        : configuration complete
//   frame_idx  : number of committed frames
module fpga_config_loader #(
    parameter int WORD_W        = fpga_config_pkg::WORD_W,
    parameter int NUM_FRAMES    = fpga_config_pkg::NUM_FRAMES,
    parameter int SETTLE_CYCLES = fpga_config_pkg::SETTLE_CYCLES
) (
    input  logic                            clock,
    input  logic                            rst,
    input  logic [7:0]                      bs_data,
    input  logic                            bs_valid,
    output logic                            bs_ready,
    output logic [WORD_W-1:0]               configs_in,
    output logic [NUM_FRAMES-1:0]           configs_en,
    output logic                            ff_en,
    output logic                            rdy,
    output logic [$clog2(NUM_FRAMES+1)-1:0] frame_idx
);
    import fpga_config_pkg::*;

    localparam int BPF = WORD_W / 8;
    localparam int BCW = $clog2(BPF + 1);
    localparam int FIW = $clog2(NUM_FRAMES + 1);
    // +2 keeps the counter at least one bit wide even with no settle time
    localparam int SCW = $clog2(SETTLE_CYCLES + 2);

    cfg_state_t        state_q, state_d;
    logic [WORD_W-1:0] configs_q, configs_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [FIW-1:0]    frame_idx_q, frame_idx_d;
    logic [SCW-1:0]    settle_q, settle_d;
    logic              ff_en_q, ff_en_d;
    logic              rdy_q, rdy_d;

    logic accept, last_byte, last_frame, settle_done;

    assign accept      = (state_q == LOAD) && bs_valid;
    assign last_byte   = (byte_cnt_q == BCW'(BPF - 1));
    assign last_frame  = (frame_idx_q == FIW'(NUM_FRAMES - 1));
    assign settle_done = (SETTLE_CYCLES == 0) || (settle_q == SCW'(SETTLE_CYCLES - 1));

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= LOAD;
            configs_q   <= '0;
            byte_cnt_q  <= '0;
            frame_idx_q <= '0;
            settle_q    <= '0;
            ff_en_q     <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            configs_q   <= configs_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_idx_q <= frame_idx_d;
            settle_q    <= settle_d;
            ff_en_q     <= ff_en_d;
            rdy_q       <= rdy_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        configs_d   = configs_q;
        byte_cnt_d  = byte_cnt_q;
        frame_idx_d = frame_idx_q;
        settle_d    = settle_q;
        ff_en_d     = ff_en_q;
        rdy_d       = rdy_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    // Earlier bytes migrate toward the MSBs
                    configs_d = (configs_q << 8) | WORD_W'(bs_data);
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        state_d    = COMMIT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                frame_idx_d = frame_idx_q + 1'b1;
                state_d     = last_frame ? SETTLE : LOAD;
            end
            SETTLE: begin
                if (settle_done) begin
                    settle_d = '0;
                    state_d  = ENABLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ENABLE: begin
                ff_en_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                rdy_d = 1'b1;
            end
            default: state_d = LOAD;
        endcase
    end

    // Outputs
    always_comb begin
        bs_ready   = (state_q == LOAD);
        configs_en = '0;
        if (state_q == COMMIT)
            configs_en = NUM_FRAMES'(1) << frame_idx_q;
    end

    assign configs_in = configs_q;
    assign ff_en      = ff_en_q;
    assign rdy        = rdy_q;
    assign frame_idx  = frame_idx_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader: default-size instance driven through full
// loads (table of source patterns), plus a one-frame instance for timing.
module tb_fpga_config_loader;
    import fpga_config_pkg::*;

    localparam int BPF = BYTES_PER_FRAME;
    localparam int FIW = $clog2(NUM_FRAMES + 1);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                  rst;
    logic [7:0]            bs_data;
    logic                  bs_valid;
    logic                  bs_ready;
    logic [WORD_W-1:0]     configs_in;
    logic [NUM_FRAMES-1:0] configs_en;
    logic                  ff_en, rdy;
    logic [FIW-1:0]        frame_idx;

    logic [7:0]            bs_data1;
    logic                  bs_valid1;
    logic                  bs_ready1;
    logic [WORD_W-1:0]     configs_in1;
    logic [0:0]            configs_en1;
    logic                  ff_en1, rdy1;
    logic [0:0]            frame_idx1;

    fpga_config_loader dut (
        .clock(clock), .rst(rst), .bs_data(bs_data), .bs_valid(bs_valid),
        .bs_ready(bs_ready), .configs_in(configs_in), .configs_en(configs_en),
        .ff_en(ff_en), .rdy(rdy), .frame_idx(frame_idx)
    );

    fpga_config_loader #(.NUM_FRAMES(1)) dut1 (
        .clock(clock), .rst(rst), .bs_data(bs_data1), .bs_valid(bs_valid1),
        .bs_ready(bs_ready1), .configs_in(configs_in1), .configs_en(configs_en1),
        .ff_en(ff_en1), .rdy(rdy1), .frame_idx(frame_idx1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                idx;
        logic [WORD_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit stall;
        int pat;
        int exp_rdy;   // 0: cycle count not checked
    } vec_t;
    vec_t vt[4];

    int cyc;
    always @(posedge clock) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] frame_val(input int pat, input int i);
        logic [WORD_W-1:0] v;
        logic [7:0]        b;
        v = '0;
        for (int j = 0; j < BPF; j++) begin
            b = (pat == 0) ? 8'(i) : 8'(i * 5 + j + 1);
            v = (v << 8) | WORD_W'(b);
        end
        return v;
    endfunction

    // Commit monitor (main instance)
    int                rdy_cyc, ff_cyc;
    bit                post_commit = 1'b0;
    logic [WORD_W-1:0] commit_data;
    always @(negedge clock) begin
        exp_t e;
        if (post_commit && !rst)
            chk("configs_in_hold_after_commit", configs_in, commit_data);
        post_commit = 1'b0;
        if (configs_en != '0) begin
            chk("commit_onehot_not_ready", WORD_W'({$countones(configs_en) == 1, bs_ready}), WORD_W'(2'b10));
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_commit: got en %0h want none", configs_en);
            end else begin
                e = sb.pop_front();
                chk("configs_en", WORD_W'(configs_en), WORD_W'(NUM_FRAMES'(1) << e.idx));
                chk("configs_in", configs_in, e.data);
            end
            commit_data = configs_in;
            post_commit = 1'b1;
        end
        if (ff_en && ff_cyc < 0) ff_cyc = cyc;
        if (rdy && rdy_cyc < 0) rdy_cyc = cyc;
    end

    // One-frame instance monitor
    int                en1_cnt = 0, en1_cyc = -1, ff1_cyc = -1, rdy1_cyc = -1;
    logic [WORD_W-1:0] data1;
    always @(negedge clock) begin
        if (configs_en1 != '0) begin
            en1_cnt++;
            en1_cyc = cyc;
            data1   = configs_in1;
        end
        if (ff_en1 && ff1_cyc < 0) ff1_cyc = cyc;
        if (rdy1 && rdy1_cyc < 0) rdy1_cyc = cyc;
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit acc;
        int n;
        n = 0;
        bs_data  = b;
        bs_valid = 1'b1;
        do begin
            acc = bs_ready;
            @(posedge clock); #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL byte_accept_timeout: got no accept want accept within 100 cycles");
        end
        if (stall) begin
            bs_valid = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic send_frame(input int idx, input int pat, input bit stall);
        logic [WORD_W-1:0] v;
        v = frame_val(pat, idx);
        sb.push_back('{idx, v});
        for (int j = 0; j < BPF; j++)
            send_byte(v[WORD_W-1-8*j -: 8], stall);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bs_valid  = 1'b0;
        bs_valid1 = 1'b0;
        ff_cyc    = -1;
        rdy_cyc   = -1;
        @(posedge clock); @(posedge clock); #1;
        rst = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_configs_in"}, configs_in, '0);
        chk({tag, "_en_ff_rdy_ready"}, WORD_W'({configs_en, ff_en, rdy, bs_ready}), WORD_W'(1));
        chk({tag, "_frame_idx"}, WORD_W'(frame_idx), '0);
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!rdy && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL rdy_timeout: got rdy 0 want 1 within 200 cycles");
        end
        @(negedge clock); #1;
    endtask

    task automatic full_load(input int pat, input bit stall, input int exp_rdy);
        for (int i = 0; i < NUM_FRAMES; i++)
            send_frame(i, pat, stall);
        wait_rdy();
        chk("sb_drained", WORD_W'(sb.size()), '0);
        chk("final_frame_idx", WORD_W'(frame_idx), WORD_W'(NUM_FRAMES));
        chk("final_configs_in", configs_in, frame_val(pat, NUM_FRAMES - 1));
        chk("rdy_after_ff_en", WORD_W'(rdy_cyc - ff_cyc), WORD_W'(1));
        if (exp_rdy != 0) begin
            chk("rdy_cycle", WORD_W'(rdy_cyc), WORD_W'(exp_rdy));
            chk("ff_en_cycle", WORD_W'(ff_cyc), WORD_W'(exp_rdy - 1));
        end
    endtask

    initial begin
        logic [WORD_W-1:0] exp1;
        logic [WORD_W-1:0] hold;

        vt[0] = '{1'b0, 0, 1259};
        vt[1] = '{1'b1, 0, 0};
        vt[2] = '{1'b0, 1, 1259};
        vt[3] = '{1'b1, 1, 0};

        bs_data  = '0;
        bs_data1 = '0;

        // One-frame instance, bytes 0x01..0x1C back-to-back
        do_reset();
        chk_cleared("reset");
        chk("reset1_ready", WORD_W'({bs_ready1, configs_en1, ff_en1, rdy1}), WORD_W'(4'b1000));
        exp1 = '0;
        bs_valid1 = 1'b1;
        for (int b = 1; b <= BPF; b++) begin
            bs_data1 = 8'(b);
            exp1 = (exp1 << 8) | WORD_W'(8'(b));
            @(posedge clock); #1;
        end
        bs_valid1 = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        chk("one_frame_configs_in", data1, exp1);
        chk("one_frame_en_pulses", WORD_W'(en1_cnt), WORD_W'(1));
        chk("one_frame_en_cycle", WORD_W'(en1_cyc), WORD_W'(BPF));
        chk("one_frame_ff_en_delay", WORD_W'(ff1_cyc - en1_cyc - 1), WORD_W'(SETTLE_CYCLES + 1));
        chk("one_frame_rdy_delay", WORD_W'(rdy1_cyc - ff1_cyc), WORD_W'(1));

        // Full loads from the vector table
        foreach (vt[k]) begin
            do_reset();
            chk_cleared("reset");
            full_load(vt[k].pat, vt[k].stall, vt[k].exp_rdy);

            // Bytes offered in DONE are ignored
            hold     = configs_in;
            bs_data  = 8'h55;
            bs_valid = 1'b1;
            for (int c = 0; c < 4; c++) begin
                chk("done_not_ready", WORD_W'({bs_ready, rdy, ff_en}), WORD_W'(3'b011));
                @(posedge clock); #1;
            end
            chk("done_configs_hold", configs_in, hold);
            chk("done_frame_idx", WORD_W'(frame_idx), WORD_W'(NUM_FRAMES));

            // Reset from DONE
            rst = 1'b1;
            @(posedge clock); #1;
            chk_cleared("rst_in_done");
            rst = 1'b0;
            bs_valid = 1'b0;
        end

        // Reset after 5 frames plus 10 bytes, then a clean full load
        do_reset();
        for (int i = 0; i < 5; i++)
            send_frame(i, 0, 1'b0);
        for (int j = 0; j < 10; j++)
            send_byte(8'hA0 + 8'(j), 1'b0);
        chk("mid_frame_idx", WORD_W'(frame_idx), WORD_W'(5));
        rst = 1'b1;
        ff_cyc  = -1;
        rdy_cyc = -1;
        @(posedge clock); #1;
        chk_cleared("rst_mid_frame");
        chk("sb_empty_at_rst", WORD_W'(sb.size()), '0);
        rst = 1'b0;
        full_load(1, 1'b0, 1259);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
